// File: rtl/mem_bus_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// mem_bus_pkg
// Shared definitions for the criscv memory-bus controller:
//   - FSM state encoding (IDLE / REQ / DONE)
//   - target-select encoding (boot RAM, SDRAM MMU, peripherals)
//   - default boot-RAM limit, bus-error read data, timeout length
//   - access size codes carried unchanged through the controller
//   - helper turning a target select into the one-hot request vector
// ---------------------------------------------------------------------------
package mem_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        TGT_BOOT  = 2'd0,
        TGT_SDRAM = 2'd1,
        TGT_PER   = 2'd2
    } tgt_e;

    localparam logic [31:0] BOOT_LIMIT_DEF     = 32'h0001_0000;
    localparam logic [31:0] ERR_DATA_DEF       = 32'hDEAD_BEEF;
    localparam int unsigned TIMEOUT_CYCLES_DEF = 1024;

    // Access size codes; the controller forwards them untouched.
    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    // Request vector ordering is {per, sdram, boot}.
    function automatic logic [2:0] tgt_onehot(input tgt_e t);
        case (t)
            TGT_BOOT:  return 3'b001;
            TGT_SDRAM: return 3'b010;
            TGT_PER:   return 3'b100;
            default:   return 3'b000;
        endcase
    endfunction

endpackage

// File: rtl/mem_bus_ctrl_decode.sv
// ---------------------------------------------------------------------------
// mem_bus_decode
// Purely combinational address decoder, also reused by the top-level LED
// logic.
//   bit31 = 1                 -> TGT_PER
//   address < BOOT_LIMIT      -> TGT_BOOT   (unsigned 32-bit compare)
//   otherwise                 -> TGT_SDRAM
// Ports:
//   addr_i  in  32  address to classify
//   tgt_o   out  2  target select (mem_bus_pkg::tgt_e)
// ---------------------------------------------------------------------------
module mem_bus_decode
    import mem_bus_pkg::*;
#(
    parameter logic [31:0] BOOT_LIMIT = BOOT_LIMIT_DEF
) (
    input  logic [31:0] addr_i,
    output tgt_e        tgt_o
);

    always_comb begin
        tgt_o = TGT_SDRAM;
        if (addr_i[31]) begin
            tgt_o = TGT_PER;
        end else if (addr_i < BOOT_LIMIT) begin
            tgt_o = TGT_BOOT;
        end
    end

endmodule

// File: rtl/mem_bus_ctrl.sv
// ---------------------------------------------------------------------------
// mem_bus_ctrl
// Registered bus controller between the criscv memory port and the three
// memory-bus targets (boot RAM, SDRAM MMU, peripherals).
//
// Handshake (CPU side, four-phase): CPU raises rw_req and holds it until it
// sees rec; rec stays high (with read_data/bus_err stable) until rw_req is
// sampled low, then rec drops. Target side: exactly one *_req is held high
// until the selected target's *_rec is sampled high; recs from other targets,
// or arriving outside REQ, are ignored.
//
// Optional feature: define BUS_TIMEOUT_EN to add a 16-bit wait-state counter
// that completes a stuck request with bus_err=1 and ERR_DATA after
// TIMEOUT_CYCLES REQ cycles. Without it REQ waits forever and bus_err is 0.
//
// Ports:
//   mclk, reset                  clock, async active-low reset
//   address/rw_req/rw/           CPU request
//   write_data/size
//   read_data/rec/bus_err        CPU response (registered)
//   t_address/t_rw/              latched request to all targets
//   t_write_data/t_size
//   boot/sdram/per_req           per-target request (one-hot or zero)
//   boot/sdram/per_rdata, _rec   target responses
//   dbg_state_o                  current FSM state (debug)
// ---------------------------------------------------------------------------
module mem_bus_ctrl
    import mem_bus_pkg::*;
#(
    parameter logic [31:0] BOOT_LIMIT     = BOOT_LIMIT_DEF
`ifdef BUS_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
    parameter logic [31:0] ERR_DATA       = ERR_DATA_DEF
`endif
) (
    input  logic        mclk,
    input  logic        reset,
    input  logic [31:0] address,
    input  logic        rw_req,
    input  logic        rw,
    input  logic [31:0] write_data,
    input  logic [1:0]  size,
    output logic [31:0] read_data,
    output logic        rec,
    output logic        bus_err,
    output logic [31:0] t_address,
    output logic        t_rw,
    output logic [31:0] t_write_data,
    output logic [1:0]  t_size,
    output logic        boot_req,
    output logic        sdram_req,
    output logic        per_req,
    input  logic [31:0] boot_rdata,
    input  logic [31:0] sdram_rdata,
    input  logic [31:0] per_rdata,
    input  logic        boot_rec,
    input  logic        sdram_rec,
    input  logic        per_rec,
    output state_e      dbg_state_o
);

    state_e      state_q;
    tgt_e        sel_q;
    tgt_e        dec_tgt;
    logic [2:0]  req_q;        // {per, sdram, boot}
    logic [31:0] read_data_q;
    logic        rec_q;
    logic [31:0] t_address_q;
    logic        t_rw_q;
    logic [31:0] t_write_data_q;
    logic [1:0]  t_size_q;
    logic        sel_rec;
    logic [31:0] sel_rdata;

    // Decode the live CPU address; it is only consumed on the IDLE accept
    // edge, so the latched select stays stable for the whole transaction.
    mem_bus_decode #(
        .BOOT_LIMIT (BOOT_LIMIT)
    ) u_decode (
        .addr_i (address),
        .tgt_o  (dec_tgt)
    );

    // Only the selected target's completion and data are ever looked at.
    always_comb begin
        sel_rec   = 1'b0;
        sel_rdata = 32'h0;
        case (sel_q)
            TGT_BOOT: begin
                sel_rec   = boot_rec;
                sel_rdata = boot_rdata;
            end
            TGT_SDRAM: begin
                sel_rec   = sdram_rec;
                sel_rdata = sdram_rdata;
            end
            TGT_PER: begin
                sel_rec   = per_rec;
                sel_rdata = per_rdata;
            end
            default: begin
                sel_rec   = 1'b0;
                sel_rdata = 32'h0;
            end
        endcase
    end

`ifdef BUS_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] wait_cnt_q;
    logic        bus_err_q;

    always_ff @(posedge mclk or negedge reset) begin
        if (!reset) begin
            state_q        <= ST_IDLE;
            sel_q          <= TGT_BOOT;
            req_q          <= 3'b000;
            read_data_q    <= 32'h0;
            rec_q          <= 1'b0;
            bus_err_q      <= 1'b0;
            t_address_q    <= 32'h0;
            t_rw_q         <= 1'b0;
            t_write_data_q <= 32'h0;
            t_size_q       <= 2'd0;
            wait_cnt_q     <= 16'h0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (rw_req) begin
                        t_address_q    <= address;
                        t_rw_q         <= rw;
                        t_write_data_q <= write_data;
                        t_size_q       <= size;
                        sel_q          <= dec_tgt;
                        req_q          <= tgt_onehot(dec_tgt);
                        wait_cnt_q     <= 16'h0;
                        state_q        <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    // A real completion beats a coincident expiry.
                    if (sel_rec) begin
                        read_data_q <= sel_rdata;
                        req_q       <= 3'b000;
                        rec_q       <= 1'b1;
                        bus_err_q   <= 1'b0;
                        state_q     <= ST_DONE;
                    end else if (wait_cnt_q == TIMEOUT_LAST) begin
                        read_data_q <= ERR_DATA;
                        req_q       <= 3'b000;
                        rec_q       <= 1'b1;
                        bus_err_q   <= 1'b1;
                        state_q     <= ST_DONE;
                    end else begin
                        wait_cnt_q  <= wait_cnt_q + 16'h1;
                    end
                end
                ST_DONE: begin
                    if (!rw_req) begin
                        rec_q     <= 1'b0;
                        bus_err_q <= 1'b0;
                        state_q   <= ST_IDLE;
                    end
                end
                default: begin
                    req_q   <= 3'b000;
                    rec_q   <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus_err = bus_err_q;
`else
    always_ff @(posedge mclk or negedge reset) begin
        if (!reset) begin
            state_q        <= ST_IDLE;
            sel_q          <= TGT_BOOT;
            req_q          <= 3'b000;
            read_data_q    <= 32'h0;
            rec_q          <= 1'b0;
            t_address_q    <= 32'h0;
            t_rw_q         <= 1'b0;
            t_write_data_q <= 32'h0;
            t_size_q       <= 2'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (rw_req) begin
                        t_address_q    <= address;
                        t_rw_q         <= rw;
                        t_write_data_q <= write_data;
                        t_size_q       <= size;
                        sel_q          <= dec_tgt;
                        req_q          <= tgt_onehot(dec_tgt);
                        state_q        <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    // Write completions also capture rdata; value is unused.
                    if (sel_rec) begin
                        read_data_q <= sel_rdata;
                        req_q       <= 3'b000;
                        rec_q       <= 1'b1;
                        state_q     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (!rw_req) begin
                        rec_q   <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    req_q   <= 3'b000;
                    rec_q   <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus_err = 1'b0;
`endif

    assign boot_req     = req_q[0];
    assign sdram_req    = req_q[1];
    assign per_req      = req_q[2];
    assign read_data    = read_data_q;
    assign rec          = rec_q;
    assign t_address    = t_address_q;
    assign t_rw         = t_rw_q;
    assign t_write_data = t_write_data_q;
    assign t_size       = t_size_q;
    assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
module tb_mem_bus_ctrl;
  import mem_bus_pkg::*;

  localparam logic [31:0] BOOT_LIM = 32'h0001_0000;
  localparam logic [31:0] ERR_WORD = 32'hDEAD_BEEF;
  localparam int TO_CYC = 8;
`ifdef BUS_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        mclk;
  logic        reset;
  logic [31:0] address;
  logic        rw_req;
  logic        rw;
  logic [31:0] write_data;
  logic [1:0]  size;
  logic [31:0] read_data;
  logic        rec;
  logic        bus_err;
  logic [31:0] t_address;
  logic        t_rw;
  logic [31:0] t_write_data;
  logic [1:0]  t_size;
  logic        boot_req, sdram_req, per_req;
  logic [31:0] boot_rdata, sdram_rdata, per_rdata;
  logic        boot_rec, sdram_rec, per_rec;
  state_e      dbg_state;

  mem_bus_ctrl #(
    .BOOT_LIMIT     (BOOT_LIM)
`ifdef BUS_TIMEOUT_EN
    ,
    .TIMEOUT_CYCLES (TO_CYC),
    .ERR_DATA       (ERR_WORD)
`endif
  ) dut (
    .mclk         (mclk),
    .reset        (reset),
    .address      (address),
    .rw_req       (rw_req),
    .rw           (rw),
    .write_data   (write_data),
    .size         (size),
    .read_data    (read_data),
    .rec          (rec),
    .bus_err      (bus_err),
    .t_address    (t_address),
    .t_rw         (t_rw),
    .t_write_data (t_write_data),
    .t_size       (t_size),
    .boot_req     (boot_req),
    .sdram_req    (sdram_req),
    .per_req      (per_req),
    .boot_rdata   (boot_rdata),
    .sdram_rdata  (sdram_rdata),
    .per_rdata    (per_rdata),
    .boot_rec     (boot_rec),
    .sdram_rec    (sdram_rec),
    .per_rec      (per_rec),
    .dbg_state_o  (dbg_state)
  );

  // ---------------- clock ----------------
  initial begin
    mclk = 1'b0;
    forever #5 mclk = ~mclk;
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference decode: peripherals live in the upper half of the map, boot RAM
  // is the bottom BOOT_LIM bytes, everything else is SDRAM. Result {per,sdram,boot}.
  function automatic logic [2:0] ref_tgt(input logic [31:0] a);
    if (a >= 32'h8000_0000) return 3'b100;
    if (a < BOOT_LIM)       return 3'b001;
    return 3'b010;
  endfunction

  // ---------------- driver: one complete CPU transaction ----------------
  // Targets are modelled here: the selected one answers after `w` cycles of
  // seeing its request; with spur set, the non-selected ones assert rec the
  // whole time. Latency counts negedges from raising rw_req to seeing rec.
  task automatic run_txn(input logic [31:0] a, input logic wr, input logic [31:0] wd,
                         input logic [1:0] sz, input int w, input logic [2:0] exp_oh,
                         input logic [31:0] rd, input bit spur, input bit drop_early,
                         input int hold);
    int  k;
    bit  got;
    bit  to;
    logic [31:0] exp_rd;
    to = TO_EN && (w >= TO_CYC);
    exp_rd = to ? ERR_WORD : rd;
    boot_rdata  = exp_oh[0] ? rd : $urandom;
    sdram_rdata = exp_oh[1] ? rd : $urandom;
    per_rdata   = exp_oh[2] ? rd : $urandom;
    address = a; rw = wr; write_data = wd; size = sz; rw_req = 1'b1;
    k = 0; got = 0;
    while (!got && k < 60) begin
      @(negedge mclk);
      k++;
      if (rec) begin
        got = 1;
      end else begin
        chk("req_onehot", {29'h0, per_req, sdram_req, boot_req}, {29'h0, exp_oh});
        chk("t_address_req", t_address, a);
        boot_rec  = exp_oh[0] ? (k > w) : spur;
        sdram_rec = exp_oh[1] ? (k > w) : spur;
        per_rec   = exp_oh[2] ? (k > w) : spur;
        address = $urandom; write_data = $urandom; rw = $urandom_range(0, 1);
        size = 2'($urandom_range(0, 3));
        if (drop_early) rw_req = 1'b0;
      end
    end
    boot_rec = 1'b0; sdram_rec = 1'b0; per_rec = 1'b0;
    chk("rec_seen", {31'h0, got}, 32'h1);
    if (got) begin
      chk("latency", 32'(k), to ? 32'(TO_CYC + 1) : 32'(w + 2));
      chk("bus_err", {31'h0, bus_err}, {31'h0, to});
      if (!wr || to) chk("read_data", read_data, exp_rd);
      chk("req_drop", {29'h0, per_req, sdram_req, boot_req}, 32'h0);
      chk("t_address", t_address, a);
      chk("t_rw", {31'h0, t_rw}, {31'h0, wr});
      chk("t_write_data", t_write_data, wd);
      chk("t_size", {30'h0, t_size}, {30'h0, sz});
      if (!drop_early) begin
        for (int h = 0; h < hold; h++) begin
          // late / stray target completions must not disturb the held response
          boot_rec = $urandom_range(0, 1); sdram_rec = $urandom_range(0, 1);
          per_rec = $urandom_range(0, 1);
          boot_rdata = $urandom; sdram_rdata = $urandom; per_rdata = $urandom;
          address = $urandom;
          @(negedge mclk);
          chk("rec_hold", {31'h0, rec}, 32'h1);
          if (!wr || to) chk("read_data_hold", read_data, exp_rd);
          chk("t_address_hold", t_address, a);
        end
        boot_rec = 1'b0; sdram_rec = 1'b0; per_rec = 1'b0;
        rw_req = 1'b0;
      end
      @(negedge mclk);
      chk("rec_drop", {31'h0, rec}, 32'h0);
      chk("bus_err_drop", {31'h0, bus_err}, 32'h0);
      chk("idle_no_req", {29'h0, per_req, sdram_req, boot_req}, 32'h0);
    end else begin
      rw_req = 1'b0;
      @(negedge mclk);
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [31:0] wdata;
    logic [1:0]  sz;
    int          w;
    logic [2:0]  exp_oh;
    logic [31:0] rdata;
    bit          spur;
  } vec_t;

  vec_t vecs[10];

  initial begin
    vecs[0] = '{32'h0000_0100, 1'b0, 32'h0,          2'd2, 0, 3'b001, 32'h1234_5678, 1'b0};
    vecs[1] = '{32'h0002_0000, 1'b1, 32'hCAFE_F00D,  2'd2, 5, 3'b010, 32'h5555_AAAA, 1'b0};
    vecs[2] = '{32'h0000_FFFF, 1'b0, 32'h0,          2'd0, 1, 3'b001, 32'hA1A1_0001, 1'b0};
    vecs[3] = '{32'h0001_0000, 1'b0, 32'h0,          2'd1, 0, 3'b010, 32'hB2B2_0002, 1'b0};
    vecs[4] = '{32'h7FFF_FFFF, 1'b0, 32'h0,          2'd0, 2, 3'b010, 32'hC3C3_0003, 1'b0};
    vecs[5] = '{32'h8000_0000, 1'b0, 32'h0,          2'd2, 0, 3'b100, 32'hD4D4_0004, 1'b0};
    vecs[6] = '{32'h8000_1000, 1'b0, 32'h0,          2'd2, 4, 3'b100, 32'hE5E5_0005, 1'b1};
    vecs[7] = '{32'h0000_0000, 1'b1, 32'h0BAD_F00D,  2'd1, 3, 3'b001, 32'h0,         1'b1};
    vecs[8] = '{32'hFFFF_FFFC, 1'b1, 32'h1357_9BDF,  2'd2, 1, 3'b100, 32'h0,         1'b0};
    vecs[9] = '{32'h0001_0004, 1'b0, 32'h0,          2'd2, 6, 3'b010, 32'hF6F6_0006, 1'b1};
  end

  // ---------------- main sequence ----------------
  initial begin
    reset = 1'b0; rw_req = 1'b0; rw = 1'b0; address = 32'h0; write_data = 32'h0;
    size = 2'd0; boot_rdata = 32'h0; sdram_rdata = 32'h0; per_rdata = 32'h0;
    boot_rec = 1'b0; sdram_rec = 1'b0; per_rec = 1'b0;
    repeat (2) @(negedge mclk);

    // reset state
    chk("rst_rec", {31'h0, rec}, 32'h0);
    chk("rst_bus_err", {31'h0, bus_err}, 32'h0);
    chk("rst_read_data", read_data, 32'h0);
    chk("rst_req", {29'h0, per_req, sdram_req, boot_req}, 32'h0);
    chk("rst_t_address", t_address, 32'h0);
    chk("rst_t_wd", t_write_data, 32'h0);
    chk("rst_state", {30'h0, dbg_state}, {30'h0, ST_IDLE});
    reset = 1'b1;
    @(negedge mclk);

    // directed table
    for (int i = 0; i < 10; i++) begin
      run_txn(vecs[i].addr, vecs[i].wr, vecs[i].wdata, vecs[i].sz, vecs[i].w,
              vecs[i].exp_oh, vecs[i].rdata, vecs[i].spur, 1'b0, 2);
    end

    // rw_req dropped during REQ: still completes, DONE left straight away
    run_txn(32'h0000_0200, 1'b0, 32'h0, 2'd2, 3, 3'b001, 32'h7777_8888, 1'b0, 1'b1, 0);

    // reset asserted mid-REQ
    address = 32'h0000_0300; rw = 1'b0; rw_req = 1'b1;
    @(negedge mclk);
    @(negedge mclk);
    chk("pre_reset_boot_req", {31'h0, boot_req}, 32'h1);
    reset = 1'b0;
    #1;
    chk("async_rst_req", {29'h0, per_req, sdram_req, boot_req}, 32'h0);
    chk("async_rst_rec", {31'h0, rec}, 32'h0);
    chk("async_rst_t_address", t_address, 32'h0);
    rw_req = 1'b0;
    @(negedge mclk);
    reset = 1'b1;
    @(negedge mclk);
    run_txn(32'h9000_0010, 1'b0, 32'h0, 2'd2, 1, 3'b100, 32'h4242_4242, 1'b0, 1'b0, 1);

`ifdef BUS_TIMEOUT_EN
    // no response at all -> bus error; response on the expiry cycle wins
    run_txn(32'h0004_0000, 1'b0, 32'h0, 2'd2, 1000, 3'b010, 32'h0, 1'b0, 1'b0, 1);
    run_txn(32'h0004_0000, 1'b1, 32'h1111_2222, 2'd2, 1000, 3'b010, 32'h0, 1'b1, 1'b0, 1);
    run_txn(32'h0000_0040, 1'b0, 32'h0, 2'd2, TO_CYC - 1, 3'b001, 32'h6060_6060, 1'b0, 1'b0, 1);
    run_txn(32'h8000_0040, 1'b0, 32'h0, 2'd2, TO_CYC - 2, 3'b100, 32'h5050_5050, 1'b0, 1'b0, 1);
`endif

    // randomized transactions against the reference decode / timing model
    for (int n = 0; n < 40; n++) begin
      logic [31:0] a;
      int cls;
      cls = $urandom_range(0, 3);
      case (cls)
        0: a = $urandom_range(32'(BOOT_LIM - 1), 0);
        1: a = $urandom_range(32'h7FFF_FFFF, 32'(BOOT_LIM));
        2: a = $urandom | 32'h8000_0000;
        default: a = $urandom;
      endcase
      run_txn(a, 1'($urandom_range(0, 1)), $urandom, 2'($urandom_range(0, 3)),
              $urandom_range(0, 6), ref_tgt(a), $urandom, 1'($urandom_range(0, 1)),
              ($urandom_range(0, 7) == 0), $urandom_range(0, 3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
